// File: rtl/line_sequencer_if.sv
// Raster/line-buffer handshake bundle for the line sequencer.
// master: output timing side (drives strobes and buffer status); slave: the sequencer.
// Ports: lineStart, frameStart, sameLine, newFrameIn in; pullLine, cacheUpdate, lineActive,
//        srcLine[7:0], repIdx[2:0], underrun, lockErr, underrunCnt[15:0] out (slave view).
interface line_sequencer_if;
  logic        lineStart;
  logic        frameStart;
  logic        sameLine;
  logic        newFrameIn;
  logic        pullLine;
  logic        cacheUpdate;
  logic        lineActive;
  logic [7:0]  srcLine;
  logic [2:0]  repIdx;
  logic        underrun;
  logic        lockErr;
  logic [15:0] underrunCnt;

  modport master (
    output lineStart, frameStart, sameLine, newFrameIn,
    input  pullLine, cacheUpdate, lineActive, srcLine, repIdx, underrun, lockErr, underrunCnt
  );

  modport slave (
    input  lineStart, frameStart, sameLine, newFrameIn,
    output pullLine, cacheUpdate, lineActive, srcLine, repIdx, underrun, lockErr, underrunCnt
  );
endinterface

// File: rtl/line_sequencer.sv
// Purpose: per-output-line scheduler; pulls GBA lines from the line buffer, repeats each SCALE
//          times, refreshes the line cache and tracks frame lock / underruns.
// Latency: all outputs registered, 1 cycle after lineStart; cacheUpdate PULL_LAT cycles after pullLine.
// Backpressure: sameLine=1 at a pull point skips the pull (line repeated) and flags an underrun.
// Ports: clk, rstN (async active-low), bus (line_sequencer_if.slave).
// Option: define LINE_SEQ_UNDERRUN_STATS_EN to build the saturating 16-bit underrunCnt.
module line_sequencer #(
  parameter int SRC_LINES    = 160,
  parameter int SCALE        = 4,
  parameter int ACTIVE_START = 40,
  parameter int PULL_LAT     = 2
) (
  input  logic             clk,
  input  logic             rstN,
  line_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE, DONE} seqStateT;

  seqStateT    state, stateNxt;
  logic [9:0]  lineCnt, lineCntNxt;
  logic [7:0]  srcLineQ, srcLineNxt;
  logic [2:0]  repIdxQ, repIdxNxt;
  logic        lineActiveQ, lineActiveNxt;
  logic        pullLineQ, pullNxt;
  logic        cacheUpdateQ;
  logic        lockErrQ, lockErrNxt;
  logic        underrunQ;
  logic [3:0]  cacheCnt;
  logic        cacheNow;     // cache reload without a pull (first active line)
  logic        cacheArm;     // start PULL_LAT countdown behind a pull
  logic        underrunSet;
  logic        underrunClr;
  logic        lastRep;
  logic        lastSrc;

  assign lastRep = (repIdxQ  == 3'(SCALE - 1));
  assign lastSrc = (srcLineQ == 8'(SRC_LINES - 1));

  always_comb begin
    stateNxt      = state;
    lineCntNxt    = lineCnt;
    srcLineNxt    = srcLineQ;
    repIdxNxt     = repIdxQ;
    lineActiveNxt = lineActiveQ;
    pullNxt       = 1'b0;
    cacheNow      = 1'b0;
    cacheArm      = 1'b0;
    underrunSet   = 1'b0;
    underrunClr   = 1'b0;
    lockErrNxt    = 1'b0;
    // frameStart only means anything together with lineStart
    if (bus.lineStart) begin
      case (state)
        IDLE: begin
          if (bus.frameStart && bus.newFrameIn) begin
            stateNxt    = BLANK;
            lineCntNxt  = '0;
            underrunClr = 1'b1;
          end else if (!bus.newFrameIn && !bus.sameLine) begin
            // stale line from a previous frame: throw it away
            pullNxt = 1'b1;
          end
        end
        BLANK: begin
          if (bus.frameStart) begin
            stateNxt      = IDLE;
            lineActiveNxt = 1'b0;
            lockErrNxt    = 1'b1;
          end else begin
            lineCntNxt = lineCnt + 10'd1;
            if (lineCnt + 10'd1 == 10'(ACTIVE_START)) begin
              // head of buffer is already frame line 0: load cache, no pull
              stateNxt      = ACTIVE;
              srcLineNxt    = '0;
              repIdxNxt     = '0;
              lineActiveNxt = 1'b1;
              cacheNow      = 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (bus.frameStart) begin
            stateNxt      = IDLE;
            lineActiveNxt = 1'b0;
            lockErrNxt    = 1'b1;
          end else if (!lastRep) begin
            repIdxNxt = repIdxQ + 3'd1;
          end else if (!lastSrc) begin
            repIdxNxt  = '0;
            srcLineNxt = srcLineQ + 8'd1;
            if (!bus.sameLine) begin
              pullNxt  = 1'b1;
              cacheArm = 1'b1;
            end else begin
              underrunSet = 1'b1;
            end
          end else begin
            // last line consumed; nothing left to display so no cache reload
            stateNxt      = DONE;
            lineActiveNxt = 1'b0;
            if (!bus.sameLine) pullNxt = 1'b1;
            else               underrunSet = 1'b1;
          end
        end
        DONE: begin
          if (bus.frameStart) begin
            if (bus.newFrameIn) begin
              stateNxt   = BLANK;
              lineCntNxt = '0;
            end else begin
              stateNxt   = IDLE;
              lockErrNxt = 1'b1;
            end
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      lineCnt      <= '0;
      srcLineQ     <= '0;
      repIdxQ      <= '0;
      lineActiveQ  <= 1'b0;
      pullLineQ    <= 1'b0;
      cacheUpdateQ <= 1'b0;
      lockErrQ     <= 1'b0;
      underrunQ    <= 1'b0;
      cacheCnt     <= '0;
    end else begin
      state        <= stateNxt;
      lineCnt      <= lineCntNxt;
      srcLineQ     <= srcLineNxt;
      repIdxQ      <= repIdxNxt;
      lineActiveQ  <= lineActiveNxt;
      pullLineQ    <= pullNxt;
      lockErrQ     <= lockErrNxt;
      // cacheCnt==1 at the edge that lands PULL_LAT cycles after the pull pulse
      cacheUpdateQ <= cacheNow || (cacheCnt == 4'd1);
      if (cacheArm)            cacheCnt <= 4'(PULL_LAT);
      else if (cacheCnt != '0) cacheCnt <= cacheCnt - 4'd1;
      if (underrunClr)         underrunQ <= 1'b0;
      else if (underrunSet)    underrunQ <= 1'b1;
    end
  end

`ifdef LINE_SEQ_UNDERRUN_STATS_EN
  logic [15:0] underrunCntQ;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                                      underrunCntQ <= '0;
    else if (underrunSet && underrunCntQ != 16'hFFFF) underrunCntQ <= underrunCntQ + 16'd1;
  end

  assign bus.underrunCnt = underrunCntQ;
`else
  assign bus.underrunCnt = '0;
`endif

  assign bus.pullLine    = pullLineQ;
  assign bus.cacheUpdate = cacheUpdateQ;
  assign bus.lineActive  = lineActiveQ;
  assign bus.srcLine     = srcLineQ;
  assign bus.repIdx      = repIdxQ;
  assign bus.underrun    = underrunQ;
  assign bus.lockErr     = lockErrQ;

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer with default parameters: stimulus pushes expected pulse events
// (kind + cycle) into a queue, a negedge monitor pops and compares every pulse the DUT shows;
// level outputs are checked directly at chosen output lines.
module tb_line_sequencer;
  localparam int PULL_LAT = 2;
`ifdef LINE_SEQ_UNDERRUN_STATS_EN
  localparam int EXP_CNT = 1;
`else
  localparam int EXP_CNT = 0;
`endif

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  line_sequencer_if bus();

  line_sequencer #(
    .SRC_LINES(160), .SCALE(4), .ACTIVE_START(40), .PULL_LAT(PULL_LAT)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .bus(bus)
  );

  typedef struct {int kind; int cyc;} evT;
  evT expQ[$];
  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kn(input int k);
    case (k)
      0: return "pullLine";
      1: return "cacheUpdate";
      default: return "lockErr";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic popEv(input int kind);
    evT e;
    nChecks++;
    if (expQ.size() == 0) begin
      nFails++;
      $display("FAIL unexpected %s at cycle %0d: got pulse, expected none", kn(kind), cyc);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        nFails++;
        $display("FAIL event order: got %s at cycle %0d, expected %s at cycle %0d",
                 kn(kind), cyc, kn(e.kind), e.cyc);
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (bus.pullLine === 1'b1)    popEv(0);
    if (bus.cacheUpdate === 1'b1) popEv(1);
    if (bus.lockErr === 1'b1)     popEv(2);
  end

  task automatic push(input int kind, input int c);
    evT e;
    e.kind = kind;
    e.cyc  = c;
    expQ.push_back(e);
  endtask

  // One output line: strobe for one cycle, then idle so lines are 6 cycles apart.
  task automatic line(input bit fs, input bit same, input bit nfi,
                      input bit ePull, input bit eCacheAfter, input bit eCacheNow, input bit eLock);
    int lc;
    @(negedge clk);
    bus.lineStart  = 1'b1;
    bus.frameStart = fs;
    bus.sameLine   = same;
    bus.newFrameIn = nfi;
    lc = cyc;
    if (eLock)       push(2, lc + 1);
    if (ePull)       push(0, lc + 1);
    if (eCacheNow)   push(1, lc + 1);
    if (eCacheAfter) push(1, lc + 1 + PULL_LAT);
    @(negedge clk);
    bus.lineStart  = 1'b0;
    bus.frameStart = 1'b0;
    bus.sameLine   = 1'b0;
    bus.newFrameIn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Locked-frame line n (1..680): source advances every 4 lines from line 44.
  task automatic seqLine(input int n, input bit same);
    bit adv;
    adv = (n >= 44) && ((n - 40) % 4 == 0);
    line(1'b0, same, 1'b0, adv && !same, adv && !same && (n <= 676), n == 40, 1'b0);
  endtask

  task automatic queueEmpty(input string name);
    repeat (PULL_LAT + 3) @(negedge clk);
    chk(name, expQ.size(), 0);
  endtask

  task automatic allZero(input string tag);
    chk({tag, " pullLine"},    bus.pullLine,    0);
    chk({tag, " cacheUpdate"}, bus.cacheUpdate, 0);
    chk({tag, " lineActive"},  bus.lineActive,  0);
    chk({tag, " srcLine"},     bus.srcLine,     0);
    chk({tag, " repIdx"},      bus.repIdx,      0);
    chk({tag, " underrun"},    bus.underrun,    0);
    chk({tag, " lockErr"},     bus.lockErr,     0);
    chk({tag, " underrunCnt"}, bus.underrunCnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    rstN = 1'b0;
    bus.lineStart = 1'b0; bus.frameStart = 1'b0; bus.sameLine = 1'b0; bus.newFrameIn = 1'b0;
    repeat (3) @(negedge clk);
    allZero("reset");
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // drain stale lines, then one with nothing ready, then lock
    for (int i = 0; i < 3; i++) line(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    line(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    line(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain lineActive", bus.lineActive, 0);

    // frame 1: clean
    for (int n = 1; n <= 680; n++) begin
      seqLine(n, 1'b0);
      if (n == 39)  chk("line39 lineActive", bus.lineActive, 0);
      if (n == 40)  begin chk("line40 lineActive", bus.lineActive, 1); chk("line40 srcLine", bus.srcLine, 0); end
      if (n == 101) begin chk("line101 srcLine", bus.srcLine, 15); chk("line101 repIdx", bus.repIdx, 1); end
      if (n == 679) begin chk("line679 srcLine", bus.srcLine, 159); chk("line679 repIdx", bus.repIdx, 3); end
      if (n == 680) begin chk("line680 lineActive", bus.lineActive, 0); chk("line680 underrun", bus.underrun, 0); end
    end
    queueEmpty("frame1 events drained");

    // frame 2: underrun at line 48, lock loss at line 100
    line(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 99; n++) begin
      seqLine(n, n == 48);
      if (n == 48) begin
        chk("underrun srcLine", bus.srcLine, 2);
        chk("underrun flag", bus.underrun, 1);
        chk("underrun count", bus.underrunCnt, EXP_CNT);
      end
    end
    line(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lockloss lineActive", bus.lineActive, 0);
    chk("lockloss underrun held", bus.underrun, 1);
    line(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("relock underrun cleared", bus.underrun, 0);
    chk("relock underrunCnt kept", bus.underrunCnt, EXP_CNT);

    // frame 3: clean, then misaligned frameStart from DONE
    for (int n = 1; n <= 680; n++) seqLine(n, 1'b0);
    line(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    queueEmpty("frame3 events drained");

    // relock, then reset one cycle after the first pull of the frame
    line(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 43; n++) seqLine(n, 1'b0);
    @(negedge clk);
    bus.lineStart = 1'b1;
    lc = cyc;
    push(0, lc + 1);
    @(negedge clk);
    bus.lineStart = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      allZero("midreset");
    end
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    chk("after reset lineActive", bus.lineActive, 0);
    queueEmpty("no cacheUpdate after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
